// File: rtl/axis_pps_generator.sv
// axis_pps_generator
// Generates a pulse-per-second output whose period (in aclk cycles) arrives
// over an AXI4-Stream slave. A one-entry pending slot holds the next period
// until the current interval ends. At the start of each pulse, the running
// pulse index is emitted on an AXI4-Stream master for timestamping.
module axis_pps_generator #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CNTR_WIDTH-1:0]       cfg_width,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic                        pps_data,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                      state, state_n;
    logic [CNTR_WIDTH-1:0]       cntr, cntr_n;
    logic [CNTR_WIDTH-1:0]       idx, idx_n;
    logic [CNTR_WIDTH-1:0]       period_reg, period_n;
    logic [CNTR_WIDTH-1:0]       pend_data, pend_data_n;
    logic                        pend_valid, pend_valid_n;
    logic                        pps_reg, pps_n;
    logic                        tvalid_reg, tvalid_n;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_reg, tdata_n;
    logic                        tready_reg, tready_n;

    logic                        handshake;
    logic                        wrap;
    logic [CNTR_WIDTH-1:0]       word;
    logic [CNTR_WIDTH-1:0]       word_clamped;

    // Bits above CNTR_WIDTH are deliberately ignored; fold them here so
    // they do not appear as dangling inputs.
    logic unused_tdata_bits;
    assign unused_tdata_bits = ^s_axis_tdata;

    assign handshake    = s_axis_tvalid & tready_reg;
    assign word         = s_axis_tdata[CNTR_WIDTH-1:0];
    // Periods of 0 or 1 cannot produce a distinct pulse and gap, so treat them as 2
    assign word_clamped = (word < CNTR_WIDTH'(2)) ? CNTR_WIDTH'(2) : word;
    assign wrap         = (cntr == period_reg - CNTR_WIDTH'(1));

    // Next-state logic: counter, index, period reload, pending slot, and
    // output values precomputed from the next state so outputs stay registered
    always_comb begin
        state_n      = state;
        cntr_n       = cntr;
        idx_n        = idx;
        period_n     = period_reg;
        pend_data_n  = pend_data;
        pend_valid_n = pend_valid;

        case (state)
            IDLE: begin
                if (handshake) begin
                    period_n = word_clamped;
                    cntr_n   = '0;
                    idx_n    = '0;
                    state_n  = RUN;
                end
            end
            RUN: begin
                if (wrap) begin
                    cntr_n = '0;
                    idx_n  = idx + CNTR_WIDTH'(1);
                    if (pend_valid) begin
                        period_n     = pend_data;
                        pend_valid_n = 1'b0;
                    end
                end else begin
                    cntr_n = cntr + CNTR_WIDTH'(1);
                end
                // Only accepted while the slot is empty, so this never
                // collides with the consume above; a word taken on a wrap
                // cycle waits for the following wrap.
                if (handshake) begin
                    pend_data_n  = word_clamped;
                    pend_valid_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        pps_n    = (state_n == RUN) && (cntr_n < cfg_width);
        tvalid_n = (state_n == RUN) && (cntr_n == '0);
        tdata_n  = '0;
        tdata_n[CNTR_WIDTH-1:0] = idx_n;
        tready_n = (state_n == IDLE) || !pend_valid_n;
    end

    // State and registered outputs, cleared by synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= IDLE;
            cntr       <= '0;
            idx        <= '0;
            period_reg <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            pps_reg    <= 1'b0;
            tvalid_reg <= 1'b0;
            tdata_reg  <= '0;
            tready_reg <= 1'b0;
        end else begin
            state      <= state_n;
            cntr       <= cntr_n;
            idx        <= idx_n;
            period_reg <= period_n;
            pend_data  <= pend_data_n;
            pend_valid <= pend_valid_n;
            pps_reg    <= pps_n;
            tvalid_reg <= tvalid_n;
            tdata_reg  <= tdata_n;
            tready_reg <= tready_n;
        end
    end

    assign s_axis_tready = tready_reg;
    assign pps_data      = pps_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tdata  = tdata_reg;

endmodule

// File: tb/tb_axis_pps_generator.sv
// Directed testbench for axis_pps_generator: a 32-bit instance for the main
// scenarios and a 4-bit counter instance for index wraparound.
module tb_axis_pps_generator;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] cfg_width;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        pps_data;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;

    logic [3:0]  cfg_width4;
    logic [7:0]  s4_tdata;
    logic        s4_tvalid;
    logic        s4_tready;
    logic        pps4;
    logic [7:0]  m4_tdata;
    logic        m4_tvalid;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    axis_pps_generator #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32)) u_dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_width     (cfg_width),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .pps_data      (pps_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid)
    );

    axis_pps_generator #(.AXIS_TDATA_WIDTH(8), .CNTR_WIDTH(4)) u_dut4 (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_width     (cfg_width4),
        .s_axis_tdata  (s4_tdata),
        .s_axis_tvalid (s4_tvalid),
        .s_axis_tready (s4_tready),
        .pps_data      (pps4),
        .m_axis_tdata  (m4_tdata),
        .m_axis_tvalid (m4_tvalid)
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Offer a period word, wait (bounded) for tready, complete the handshake.
    task automatic send_word(input logic [31:0] val, output int waits);
        s_axis_tdata  = val;
        s_axis_tvalid = 1'b1;
        waits = 0;
        while (s_axis_tready !== 1'b1 && waits < 100) begin
            step();
            waits++;
        end
        if (waits >= 100) begin
            total++;
            bad++;
            $display("[TB] FAIL send_timeout: tready=%b after %0d cycles, required 1", s_axis_tready, waits);
        end
        step();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        step();
        step();
        total++;
        if (pps_data !== 1'b0) begin bad++; $display("[TB] FAIL rst_pps: got %b want 0", pps_data); end
        total++;
        if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
        total++;
        if (m_axis_tdata !== 32'd0) begin bad++; $display("[TB] FAIL rst_tdata: got %0d want 0", m_axis_tdata); end
        total++;
        if (s_axis_tready !== 1'b0) begin bad++; $display("[TB] FAIL rst_tready: got %b want 0", s_axis_tready); end
        aresetn = 1'b1;
        step();
        total++;
        if (s_axis_tready !== 1'b1) begin bad++; $display("[TB] FAIL rel_tready: got %b want 1", s_axis_tready); end
        step();
        total++;
        if (m_axis_tvalid !== 1'b0 || pps_data !== 1'b0) begin
            bad++; $display("[TB] FAIL idle_quiet: tvalid=%b pps=%b want 0 0", m_axis_tvalid, pps_data);
        end
    endtask

    // Period 10, width 3: strobes every 10 cycles, pps high for phases 0..2.
    task automatic test_startup();
        int w;
        cfg_width = 32'd3;
        send_word(32'd10, w);
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd0 || pps_data !== 1'b1) begin
            bad++; $display("[TB] FAIL start: tvalid=%b tdata=%0d pps=%b want 1 0 1", m_axis_tvalid, m_axis_tdata, pps_data);
        end
        for (int k = 1; k <= 30; k++) begin
            step();
            total++;
            if (m_axis_tvalid !== ((k % 10) == 0)) begin
                bad++; $display("[TB] FAIL start_tvalid k=%0d: got %b want %b", k, m_axis_tvalid, (k % 10) == 0);
            end
            total++;
            if (pps_data !== ((k % 10) < 3)) begin
                bad++; $display("[TB] FAIL start_pps k=%0d: got %b want %b", k, pps_data, (k % 10) < 3);
            end
            if ((k % 10) == 0) begin
                total++;
                if (m_axis_tdata !== 32'(k / 10)) begin
                    bad++; $display("[TB] FAIL start_tdata k=%0d: got %0d want %0d", k, m_axis_tdata, k / 10);
                end
            end
        end
    endtask

    // Entered at phase 0, idx 3, period 10.
    task automatic test_period_update();
        int w;
        int lens [3] = '{7, 4, 4};
        int exp_idx;
        step(); step(); step();
        send_word(32'd7, w);
        send_word(32'd4, w);
        total++;
        if (w !== 6) begin bad++; $display("[TB] FAIL stall_cycles: got %0d want 6", w); end
        // Second handshake completed at phase 0 of idx 4, now at phase 1.
        exp_idx = 5;
        for (int i = 0; i < 3; i++) begin
            int start;
            start = (i == 0) ? 1 : 0;
            for (int c = start; c < lens[i]; c++) begin
                step();
                if (c < lens[i] - 1) begin
                    total++;
                    if (m_axis_tvalid !== 1'b0) begin
                        bad++; $display("[TB] FAIL upd_gap i=%0d c=%0d: tvalid got 1 want 0", i, c);
                    end
                end
            end
            total++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'(exp_idx)) begin
                bad++; $display("[TB] FAIL upd_strobe i=%0d: tvalid=%b tdata=%0d want 1 %0d", i, m_axis_tvalid, m_axis_tdata, exp_idx);
            end
            exp_idx++;
        end
    endtask

    // Entered at phase 0, idx 7, period 4.
    task automatic test_same_cycle_load();
        int w;
        int lens [3] = '{10, 5, 5};
        send_word(32'd10, w);
        step(); step(); step();
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd8) begin
            bad++; $display("[TB] FAIL sc_reload: tvalid=%b tdata=%0d want 1 8", m_axis_tvalid, m_axis_tdata);
        end
        for (int c = 0; c < 9; c++) step();
        send_word(32'd5, w);
        total++;
        if (w !== 0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd9) begin
            bad++; $display("[TB] FAIL sc_wrap: waits=%0d tvalid=%b tdata=%0d want 0 1 9", w, m_axis_tvalid, m_axis_tdata);
        end
        for (int i = 0; i < 3; i++) begin
            for (int c = 1; c < lens[i]; c++) begin
                step();
                total++;
                if (m_axis_tvalid !== 1'b0) begin
                    bad++; $display("[TB] FAIL sc_gap i=%0d c=%0d: tvalid got 1 want 0", i, c);
                end
            end
            step();
            total++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'(10 + i)) begin
                bad++; $display("[TB] FAIL sc_strobe i=%0d: tvalid=%b tdata=%0d want 1 %0d", i, m_axis_tvalid, m_axis_tdata, 10 + i);
            end
        end
    endtask

    // Entered at phase 0, idx 12, period 5.
    task automatic test_width_corners();
        int w;
        int strobes;
        cfg_width = 32'd0;
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (pps_data !== 1'b0) begin bad++; $display("[TB] FAIL w0_pps k=%0d: got 1 want 0", k); end
            if (m_axis_tvalid === 1'b1) strobes++;
        end
        total++;
        if (strobes !== 2) begin bad++; $display("[TB] FAIL w0_strobes: got %0d want 2", strobes); end
        cfg_width = 32'd20;
        send_word(32'd10, w);
        step(); step(); step(); step();
        strobes = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            total++;
            if (pps_data !== 1'b1) begin bad++; $display("[TB] FAIL w20_pps k=%0d: got 0 want 1", k); end
            if (m_axis_tvalid === 1'b1) strobes++;
        end
        total++;
        if (strobes !== 2 || m_axis_tdata !== 32'd17) begin
            bad++; $display("[TB] FAIL w20_strobes: count=%0d tdata=%0d want 2 17", strobes, m_axis_tdata);
        end
        send_word(32'd1, w);
        for (int c = 1; c < 10; c++) step();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'(18 + i)) begin
                bad++; $display("[TB] FAIL p1_strobe i=%0d: tvalid=%b tdata=%0d want 1 %0d", i, m_axis_tvalid, m_axis_tdata, 18 + i);
            end
            step();
            total++;
            if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL p1_gap i=%0d: tvalid got 1 want 0", i); end
            step();
        end
    endtask

    task automatic test_index_wrap();
        int exp_seq [4] = '{14, 15, 0, 1};
        cfg_width4 = 4'd1;
        s4_tdata   = 8'd2;
        s4_tvalid  = 1'b1;
        step();
        s4_tvalid  = 1'b0;
        total++;
        if (m4_tvalid !== 1'b1 || m4_tdata !== 8'd0) begin
            bad++; $display("[TB] FAIL wrap_start: tvalid=%b tdata=%0d want 1 0", m4_tvalid, m4_tdata);
        end
        for (int k = 0; k < 28; k++) step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (m4_tvalid !== 1'b1 || m4_tdata !== 8'(exp_seq[i])) begin
                bad++; $display("[TB] FAIL wrap_seq i=%0d: tvalid=%b tdata=%0d want 1 %0d", i, m4_tvalid, m4_tdata, exp_seq[i]);
            end
            step();
            step();
        end
    endtask

    task automatic test_reset_mid();
        int w;
        int seen;
        cfg_width = 32'd20;
        send_word(32'd10, w);
        send_word(32'd7, w);
        total++;
        if (s_axis_tready !== 1'b0 || pps_data !== 1'b1) begin
            bad++; $display("[TB] FAIL mid_pre: tready=%b pps=%b want 0 1", s_axis_tready, pps_data);
        end
        aresetn = 1'b0;
        step();
        total++;
        if (pps_data !== 1'b0 || m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_rst: pps=%b tvalid=%b tready=%b want 0 0 0", pps_data, m_axis_tvalid, s_axis_tready);
        end
        aresetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (m_axis_tvalid !== 1'b0 || pps_data !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0 || s_axis_tready !== 1'b1) begin
            bad++; $display("[TB] FAIL mid_idle: active_cycles=%0d tready=%b want 0 1", seen, s_axis_tready);
        end
        send_word(32'd3, w);
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd0) begin
            bad++; $display("[TB] FAIL mid_restart: tvalid=%b tdata=%0d want 1 0", m_axis_tvalid, m_axis_tdata);
        end
    endtask

    // Scenario sequence
    initial begin
        aresetn       = 1'b0;
        cfg_width     = 32'd0;
        s_axis_tdata  = 32'd0;
        s_axis_tvalid = 1'b0;
        cfg_width4    = 4'd0;
        s4_tdata      = 8'd0;
        s4_tvalid     = 1'b0;
        test_reset();
        test_startup();
        test_period_update();
        test_same_cycle_load();
        test_width_corners();
        test_index_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
